xbtn_ctrl: RTL

Push-button peripheral behind the PUSH_BASE window of the picoVersat address decoder. Synchronises and debounces N_BTN raw button inputs and latches press events in sticky flags. Exposes level, event and interrupt-mask registers on the decoder's read/write data path. Drives btn_rd back into the decoder read mux and raises an interrupt request for enabled events.

---
 rtl/xbtn_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/xbtn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : xbtn_ctrl
//  Purpose  : Push-button peripheral for the picoVersat decoder window.
//             Synchronises and debounces N_BTN raw button pads, latches
//             press events in sticky W1C flags, exposes LEVEL / EVENT /
//             MASK registers on the decoder data path and raises irq for
//             enabled pending events.
//  Ports    :
//    clk      in   1      system clock, rising edge
//    rst      in   1      asynchronous reset, active low
//    sel      in   1      block select from the address decoder
//    we       in   1      write enable, qualified by sel
//    addr     in   2      register offset (0 LEVEL, 1 EVENT, 2 MASK, 3 rsvd)
//    data_in  in   N_BTN  write data
//    btn_rd   out  N_BTN  read data to the decoder read mux (0 when !sel)
//    btn_pad  in   N_BTN  raw asynchronous active-high button inputs
//    irq      out  1      OR of (EVENT & MASK)
//  Revision : 1.0 - initial release
// ============================================================================
module xbtn_ctrl #(
  parameter int N_BTN      = 4,       // must not exceed 4 (btn_rd read port)
  parameter int DEB_CYCLES = 500000,  // stable cycles to accept a new level
  parameter int CNT_W      = 20       // 2**CNT_W must exceed DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [N_BTN-1:0] data_in,
  output logic [N_BTN-1:0] btn_rd,
  input  logic [N_BTN-1:0] btn_pad,
  output logic             irq
);

  localparam logic [1:0]       C_ADDR_LEVEL = 2'd0;
  localparam logic [1:0]       C_ADDR_EVENT = 2'd1;
  localparam logic [1:0]       C_ADDR_MASK  = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(DEB_CYCLES - 1);

  // Two-flop synchroniser per pad.
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Architectural registers.
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_event;
  logic [N_BTN-1:0] r_mask;

  // Per-button debounce results.
  logic [N_BTN-1:0] w_level_next;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_event_clr;
  logic [N_BTN-1:0] w_event_next;
  logic             w_wr_event;
  logic             w_wr_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_pad;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: each button is STABLE while its synchronised input equals its
  // LEVEL bit and COUNTING otherwise. The counter only survives consecutive
  // differing cycles, so any return to the old level restarts the wait.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      logic [CNT_W-1:0] r_cnt;
      logic             w_differ;
      logic             w_done;

      assign w_differ        = r_sync2[i] ^ r_level[i];
      assign w_done          = w_differ && (r_cnt == C_CNT_LAST);
      assign w_level_next[i] = w_done ? r_sync2[i] : r_level[i];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_cnt <= '0;
        end else if (!w_differ || w_done) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  // Only presses (0->1) are events; releases are visible in LEVEL alone.
  assign w_rise = w_level_next & ~r_level;

  assign w_wr_event = sel && we && (addr == C_ADDR_EVENT);
  assign w_wr_mask  = sel && we && (addr == C_ADDR_MASK);

  assign w_event_clr = w_wr_event ? data_in : '0;

  // Set is OR-ed in after the clear so a coincident press is never lost.
  assign w_event_next = (r_event & ~w_event_clr) | w_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
      r_event <= '0;
      r_mask  <= '0;
    end else begin
      r_level <= w_level_next;
      r_event <= w_event_next;
      if (w_wr_mask) begin
        r_mask <= data_in;
      end
    end
  end

  // Read path is purely combinational off registered state, so a read in a
  // write cycle returns the value held before that write lands.
  always_comb begin
    btn_rd = '0;
    if (sel) begin
      case (addr)
        C_ADDR_LEVEL: btn_rd = r_level;
        C_ADDR_EVENT: btn_rd = r_event;
        C_ADDR_MASK:  btn_rd = r_mask;
        default:      btn_rd = '0;
      endcase
    end
  end

  assign irq = |(r_event & r_mask);

endmodule
`default_nettype wire
